dla_platform_interrupt_scheduler: RTL

- Merges NUM_SOURCES level interrupts (one per DLA instance) into one level line to the platform's level-to-edge (MSI) converter.
- Forces a fresh rising edge when a new source asserts, and re-arms by deasserting for GAP_CYCLES after TIMEOUT cycles while any source is still pending.
- Reports a round-robin "credited" source id per asserted window so the ISR can service instances fairly.
- Sits between the DLA instance CSR blocks and the platform interrupt converter.

---
 rtl/dla_interrupt_sched_pkg.sv | 21 ++
 rtl/dla_rr_next_index.sv | 44 ++++
 rtl/dla_platform_interrupt_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dla_interrupt_sched_pkg.sv
// -----------------------------------------------------------------------------
// dla_interrupt_sched_pkg
// Shared types and helpers for the DLA platform interrupt scheduler and its
// round-robin picker.
//   sched_state_t : scheduler FSM state (IDLE, ASSERT, GAP), 2-bit encoding
//   id_width()    : width of an index into n items, never less than 1 bit
// -----------------------------------------------------------------------------
package dla_interrupt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } sched_state_t;

  // A single-item index still needs one bit of storage.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dla_rr_next_index.sv
// -----------------------------------------------------------------------------
// dla_rr_next_index
// Combinational round-robin picker shared by the DLA arbiters. It returns the
// first requesting index strictly after last_idx, wrapping from N-1 back to 0.
// If last_idx is the only requester it is picked again. With no requests at
// all the output is last_idx.
// Ports:
//   req      in  N    request vector
//   last_idx in  IDW  index granted most recently
//   next_idx out IDW  index to grant next
// -----------------------------------------------------------------------------
module dla_rr_next_index
  import dla_interrupt_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_idx,
  output logic [IDW-1:0] next_idx
);

  int          cand;
  logic        found;
  logic [N-1:0] shifted;

  // The scan covers offsets 1..N. Offset N lands back on last_idx, which
  // re-grants a lone requester. The first hit wins.
  always_comb begin
    next_idx = last_idx;
    found    = 1'b0;
    cand     = 0;
    shifted  = '0;
    for (int off = 1; off <= N; off++) begin
      cand    = (int'(last_idx) + off) % N;
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        next_idx = IDW'(cand);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dla_platform_interrupt_scheduler.sv
// -----------------------------------------------------------------------------
// dla_platform_interrupt_scheduler
// Merges per-DLA-instance level interrupts into one level line for the
// platform's level-to-edge (MSI) converter. A new source asserting forces a
// fresh rising edge by dropping the line for a gap. A window that sees no new
// event for TIMEOUT cycles is also re-armed through a gap while anything is
// still pending. Every ASSERT window credits one source in round-robin order.
// Ports:
//   clk                            in  1            clock
//   i_sclr                         in  1            synchronous reset, active high
//   i_interrupt_level              in  NUM_SOURCES  level interrupts from DLA instances
//   i_source_enable                in  NUM_SOURCES  per-source CSR enable (0 masks the source)
//   o_interrupt_level_to_platform  out 1            merged level (high while in ASSERT)
//   o_pending                      out NUM_SOURCES  registered enabled levels
//   o_grant_id                     out IDW          source credited for the current or last window
//   o_retry_count                  out RETRY_BITS   saturating count of timeout re-arms
// -----------------------------------------------------------------------------
module dla_platform_interrupt_scheduler
  import dla_interrupt_sched_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int TIMEOUT     = 100000,
  parameter int GAP_CYCLES  = 16,
  parameter int RETRY_BITS  = 16
) (
  input  logic                               clk,
  input  logic                               i_sclr,
  input  logic [NUM_SOURCES-1:0]             i_interrupt_level,
  input  logic [NUM_SOURCES-1:0]             i_source_enable,
  output logic                               o_interrupt_level_to_platform,
  output logic [NUM_SOURCES-1:0]             o_pending,
  output logic [id_width(NUM_SOURCES)-1:0]   o_grant_id,
  output logic [RETRY_BITS-1:0]              o_retry_count
);

  localparam int IDW = id_width(NUM_SOURCES);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int GW  = id_width(GAP_CYCLES);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

  sched_state_t          state, state_n;
  logic [NUM_SOURCES-1:0] pending, pend_prev;
  logic [TW-1:0]          timer, timer_n;
  logic [GW-1:0]          gap, gap_n;
  logic [IDW-1:0]         grant, grant_n;
  logic [RETRY_BITS-1:0]  retry, retry_n;
  logic [IDW-1:0]         rr_next;
  logic                   any_pending;
  logic                   new_event;

  assign any_pending = |pending;
  assign new_event   = |(pending & ~pend_prev);

  dla_rr_next_index #(
    .N   (NUM_SOURCES),
    .IDW (IDW)
  ) u_rr (
    .req      (pending),
    .last_idx (grant),
    .next_idx (rr_next)
  );

  // Input stage and all FSM registers. Reset wins over everything. The
  // grant resets to the last index so that source 0 is scanned first.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      pending   <= '0;
      pend_prev <= '0;
      state     <= IDLE;
      timer     <= '0;
      gap       <= '0;
      grant     <= IDW'(NUM_SOURCES - 1);
      retry     <= '0;
    end else begin
      pending   <= i_interrupt_level & i_source_enable;
      pend_prev <= pending;
      state     <= state_n;
      timer     <= timer_n;
      gap       <= gap_n;
      grant     <= grant_n;
      retry     <= retry_n;
    end
  end

  // Next-state logic. Losing all pending sources beats a new event, and a
  // new event beats a timeout, so a timeout is only counted when nothing
  // newer caused the re-arm. GAP always runs to completion and ignores
  // anything that happens inside it.
  always_comb begin
    state_n = state;
    timer_n = timer;
    gap_n   = gap;
    grant_n = grant;
    retry_n = retry;
    case (state)
      IDLE: begin
        if (any_pending) begin
          state_n = ASSERT;
          timer_n = TIMER_LOAD;
          grant_n = rr_next;
        end
      end
      ASSERT: begin
        if (!any_pending) begin
          state_n = IDLE;
        end else if (new_event) begin
          state_n = GAP;
          gap_n   = GAP_LOAD;
        end else if (timer == '0) begin
          state_n = GAP;
          gap_n   = GAP_LOAD;
          if (retry != '1) begin
            retry_n = retry + RETRY_BITS'(1);
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      GAP: begin
        if (gap == '0) begin
          if (any_pending) begin
            state_n = ASSERT;
            timer_n = TIMER_LOAD;
            grant_n = rr_next;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap - GW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_interrupt_level_to_platform = (state == ASSERT);
  assign o_pending                     = pending;
  assign o_grant_id                    = grant;
  assign o_retry_count                 = retry;

endmodule
